acc_drain: RTL

Drains the accumulator's result registers to the unified buffer as a serial write stream. When the accumulator raises its full flag, the block snapshots all DEPTH result words. It then transmits them one per accepted handshake, with consecutive buffer addresses starting at a latched base address. Finally it pulses a clear request back to the accumulator. It sits between the accumulator and the unified-buffer write port.

---
 rtl/acc_drain_if.sv | 31 +++
 rtl/acc_drain.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/acc_drain_if.sv
// Write-stream bundle between the accumulator drain block, the accumulator and the unified buffer.
// Handshake: a word transfers on a rising edge where wr_valid && wr_ready; once wr_valid rises,
// wr_data/wr_addr stay stable until that transfer, and wr_valid never depends on wr_ready.
interface acc_drain_if #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                    full;
    logic [DEPTH*DATA_W-1:0] acc_data;
    logic [ADDR_W-1:0]       base_addr;
    logic                    wr_ready;
    logic                    wr_valid;
    logic [DATA_W-1:0]       wr_data;
    logic [ADDR_W-1:0]       wr_addr;
    logic                    busy;
    logic                    done;
    logic                    acc_clear;
    logic                    overrun;
    logic [1:0]              dbg_state;

    modport master (
        input  full, acc_data, base_addr, wr_ready,
        output wr_valid, wr_data, wr_addr, busy, done, acc_clear, overrun, dbg_state
    );

    modport slave (
        output full, acc_data, base_addr, wr_ready,
        input  wr_valid, wr_data, wr_addr, busy, done, acc_clear, overrun, dbg_state
    );
endinterface

// File: rtl/acc_drain.sv
// Snapshots the accumulator on a full rising edge and streams the words to the unified buffer,
// then pulses done/acc_clear. All outputs come straight from registers.
module acc_drain #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    acc_drain_if.master  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                full_q;
    logic [DATA_W-1:0]   shadow_q [DEPTH];
    logic [DATA_W-1:0]   shadow_d [DEPTH];
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                wr_valid_q, wr_valid_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clr_q, clr_d;
    logic                overrun_q, overrun_d;

    logic                start;
    logic                hs;
    logic                last;
    logic [IDX_W-1:0]    nxt_idx;

    assign start   = bus.full && !full_q;
    assign hs      = wr_valid_q && bus.wr_ready;
    assign last    = (idx_q == LAST_IDX);
    assign nxt_idx = idx_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            full_q     <= 1'b0;
            base_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_q      <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            full_q     <= bus.full;
            base_q     <= base_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clr_q      <= clr_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < DEPTH; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEND;
            SEND:    if (hs && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        base_d     = base_q;
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        clr_d      = clr_q;
        overrun_d  = overrun_q;
        for (int i = 0; i < DEPTH; i++) shadow_d[i] = shadow_q[i];

        // A rising edge of full outside IDLE is dropped but remembered until reset.
        if (start && (state_q != IDLE)) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < DEPTH; i++) shadow_d[i] = bus.acc_data[i*DATA_W +: DATA_W];
                    base_d     = bus.base_addr;
                    idx_d      = '0;
                    wr_valid_d = 1'b1;
                    wr_data_d  = bus.acc_data[DATA_W-1:0];
                    wr_addr_d  = bus.base_addr;
                    busy_d     = 1'b1;
                end
            end
            SEND: begin
                if (hs) begin
                    if (last) begin
                        wr_valid_d = 1'b0;
                        done_d     = 1'b1;
                        clr_d      = 1'b1;
                    end else begin
                        idx_d     = nxt_idx;
                        wr_data_d = shadow_q[nxt_idx];
                        wr_addr_d = base_q + ADDR_W'(nxt_idx);
                    end
                end
            end
            DONE: begin
                done_d = 1'b0;
                clr_d  = 1'b0;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.acc_clear = clr_q;
    assign bus.overrun   = overrun_q;
    assign bus.dbg_state = state_q;
endmodule
